// File: rtl/hazard_scoreboard_if.sv
// Decode-side bus of the hazard scoreboard.
// The decode/pipeline control side is the master: it presents the ID instruction and the
// branch resolution. The scoreboard is the slave: it returns the tracked destinations,
// the bypass selects, the stall/enable pair, the flush strobes and the event counters.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      IdInstr;
  logic             IdValid;
  logic             IdRegWR;
  logic             IdMemRead;
  logic             BranchF;

  logic [4:0]       RegDEX;
  logic [4:0]       RegDMEM;
  logic [4:0]       RegDWB;
  logic [1:0]       FwASel;
  logic [1:0]       FwBSel;
  logic             Stall;
  logic             EnPC;
  logic             EnIFID;
  logic             FlushIF;
  logic             FlushID;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output IdInstr, IdValid, IdRegWR, IdMemRead, BranchF,
    input  RegDEX, RegDMEM, RegDWB, FwASel, FwBSel, Stall, EnPC, EnIFID,
           FlushIF, FlushID, State, StallCnt, FlushCnt
  );

  modport slave (
    input  IdInstr, IdValid, IdRegWR, IdMemRead, BranchF,
    output RegDEX, RegDMEM, RegDWB, FwASel, FwBSel, Stall, EnPC, EnIFID,
           FlushIF, FlushID, State, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Writer-side hazard scoreboard for the 5-stage RISC-V pipeline.
// Tracks the destination of every instruction sitting in the EX, MEM and WB slots and
// derives from them the operand bypass selects, the load-use stall and the multi-cycle
// flush that follows a taken branch. Bypass selects, slot destinations, state and counters
// come from registered state only; Stall, the enables and the flush strobes also look at
// the current ID instruction and BranchF.
module hazard_scoreboard #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave bus
);

  // Tracked fields of one pipeline slot. A bubble is the all-zero value.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwr;
    logic       memrd;
  } slot_t;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;

  // Remaining flush cycles after the branch cycle itself; 3 bits cover FLUSH_CYCLES up to 7.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  localparam logic [1:0] FW_REGFILE = 2'b00;
  localparam logic [1:0] FW_MEM     = 2'b01;
  localparam logic [1:0] FW_WB      = 2'b10;

  slot_t            idSlot;
  slot_t            exSlot_q;
  slot_t            exSlot_d;
  slot_t            memSlot_q;
  slot_t            wbSlot_q;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [2:0]       flushLeft_q;
  logic [2:0]       flushLeft_d;

  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q;
  logic [CNT_W-1:0] flushCnt_d;

  logic             inFlush;
  logic             loadUseHit;
  logic             stall;
  logic             bubble;
  logic [1:0]       fwA;
  logic [1:0]       fwB;

  // Opcode, funct3 and funct7 play no part in hazard tracking.
  logic             unusedInstrBits;
  assign unusedInstrBits = ^{bus.IdInstr[31:25], bus.IdInstr[14:12], bus.IdInstr[6:0]};

  // True when a slot produces a result for register src that a bypass may pick up.
  // Loads still in MEM have no data yet, so allowLoad is only set for the WB slot.
  function automatic logic slotWrites(slot_t s, logic [4:0] src, logic allowLoad);
    return s.valid && s.regwr && (s.rd != 5'd0) && (allowLoad || !s.memrd) && (s.rd == src);
  endfunction

  // MEM is the younger writer, so it wins over WB when both hold the same register.
  function automatic logic [1:0] bypassFor(logic [4:0] src, slot_t memS, slot_t wbS);
    if (slotWrites(memS, src, 1'b0)) begin
      return FW_MEM;
    end else if (slotWrites(wbS, src, 1'b1)) begin
      return FW_WB;
    end
    return FW_REGFILE;
  endfunction

  // Slot-shaped view of the instruction in ID.
  always_comb begin
    idSlot       = '0;
    idSlot.valid = 1'b1;
    idSlot.rd    = bus.IdInstr[11:7];
    idSlot.rs1   = bus.IdInstr[19:15];
    idSlot.rs2   = bus.IdInstr[24:20];
    idSlot.regwr = bus.IdRegWR;
    idSlot.memrd = bus.IdMemRead;
  end

  // Load-use detection, stall and the decision whether EX takes a bubble this cycle.
  always_comb begin
    inFlush    = (state_q == ST_FLUSH);
    loadUseHit = exSlot_q.valid && exSlot_q.memrd && (exSlot_q.rd != 5'd0) &&
                 ((exSlot_q.rd == idSlot.rs1) || (exSlot_q.rd == idSlot.rs2));
    stall      = rst_n && !inFlush && bus.IdValid && loadUseHit && !bus.BranchF;
    bubble     = stall || bus.BranchF || inFlush || !bus.IdValid;
    exSlot_d   = bubble ? '0 : idSlot;
  end

  // Slot pipeline: ID or a bubble enters EX, everything else shifts one step and WB retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exSlot_q  <= '0;
      memSlot_q <= '0;
      wbSlot_q  <= '0;
    end else begin
      exSlot_q  <= exSlot_d;
      memSlot_q <= exSlot_q;
      wbSlot_q  <= memSlot_q;
    end
  end

  // Flush sequencer: a taken branch (re)arms the countdown, which runs out back into RUN.
  always_comb begin
    state_d     = state_q;
    flushLeft_d = flushLeft_q;
    case (state_q)
      ST_RUN: begin
        if (bus.BranchF) begin
          state_d     = ST_FLUSH;
          flushLeft_d = FLUSH_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (bus.BranchF) begin
          flushLeft_d = FLUSH_RELOAD;
        end else if (flushLeft_q == 3'd0) begin
          state_d = ST_RUN;
        end else begin
          flushLeft_d = flushLeft_q - 3'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flushLeft_d = 3'd0;
      end
    endcase
  end

  // Flush state and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flushLeft_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flushLeft_q <= flushLeft_d;
    end
  end

  // Event counter next values; both stick at all-ones instead of wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stall && !(&stallCnt_q)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (bus.BranchF && !(&flushCnt_q)) begin
      flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  // Stall-cycle and branch-pulse counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // Bypass selects for the instruction now in EX, decoded from registered slots only.
  always_comb begin
    fwA = bypassFor(exSlot_q.rs1, memSlot_q, wbSlot_q);
    fwB = bypassFor(exSlot_q.rs2, memSlot_q, wbSlot_q);
  end

  assign bus.RegDEX   = (exSlot_q.valid  && exSlot_q.regwr)  ? exSlot_q.rd  : 5'd0;
  assign bus.RegDMEM  = (memSlot_q.valid && memSlot_q.regwr) ? memSlot_q.rd : 5'd0;
  assign bus.RegDWB   = (wbSlot_q.valid  && wbSlot_q.regwr)  ? wbSlot_q.rd  : 5'd0;
  assign bus.FwASel   = fwA;
  assign bus.FwBSel   = fwB;
  assign bus.Stall    = stall;
  assign bus.EnPC     = rst_n && !stall;
  assign bus.EnIFID   = rst_n && !stall;
  assign bus.FlushIF  = rst_n && (bus.BranchF || inFlush);
  assign bus.FlushID  = rst_n && (bus.BranchF || inFlush);
  assign bus.State    = state_q;
  assign bus.StallCnt = stallCnt_q;
  assign bus.FlushCnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed hazard scenarios followed by random traffic,
// every cycle compared against an in-flight instruction list model.
module tb_hazard_scoreboard;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam longint MAX_CNT  = (longint'(1) << CNT_W) - 1;

  typedef struct {
    bit valid;
    int rd;
    int rs1;
    int rs2;
    bit regwr;
    bit memrd;
  } minstr_t;

  logic clk;
  logic rst_n;

  hazard_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Model: pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
  minstr_t pipe[$];
  int      flushLeft;
  longint  stallCount;
  longint  flushCount;

  bit          curValid;
  logic [31:0] curInstr;
  bit          curWr;
  bit          curMr;
  bit          curBr;

  function automatic logic [31:0] mkInstr(int rd, int rs1, int rs2);
    logic [4:0] d = 5'(rd);
    logic [4:0] a = 5'(rs1);
    logic [4:0] b = 5'(rs2);
    return {7'd0, b, a, 3'd0, d, 7'b0110011};
  endfunction

  function automatic minstr_t noInstr();
    minstr_t n;
    n.valid = 0; n.rd = 0; n.rs1 = 0; n.rs2 = 0; n.regwr = 0; n.memrd = 0;
    return n;
  endfunction

  task automatic modelReset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(noInstr());
    flushLeft  = 0;
    stallCount = 0;
    flushCount = 0;
  endtask

  function automatic int curRs1();
    return int'(curInstr[19:15]);
  endfunction

  function automatic int curRs2();
    return int'(curInstr[24:20]);
  endfunction

  function automatic int destOf(minstr_t s);
    return (s.valid && s.regwr) ? s.rd : 0;
  endfunction

  function automatic bit feeds(minstr_t s, int src, bit loadReady);
    return s.valid && s.regwr && s.rd != 0 && (loadReady || !s.memrd) && s.rd == src;
  endfunction

  function automatic int bypass(int src);
    if (feeds(pipe[1], src, 0)) return 1;
    if (feeds(pipe[2], src, 1)) return 2;
    return 0;
  endfunction

  function automatic bit modelStall();
    minstr_t e = pipe[0];
    return flushLeft == 0 && curValid && e.valid && e.memrd && e.rd != 0 &&
           (e.rd == curRs1() || e.rd == curRs2()) && !curBr;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic checkAll();
    bit st = modelStall();
    bit fl = curBr || flushLeft > 0;
    checkOutput("RegDEX",   32'(bus.RegDEX),   destOf(pipe[0]));
    checkOutput("RegDMEM",  32'(bus.RegDMEM),  destOf(pipe[1]));
    checkOutput("RegDWB",   32'(bus.RegDWB),   destOf(pipe[2]));
    checkOutput("FwASel",   32'(bus.FwASel),   bypass(pipe[0].rs1));
    checkOutput("FwBSel",   32'(bus.FwBSel),   bypass(pipe[0].rs2));
    checkOutput("Stall",    32'(bus.Stall),    32'(st));
    checkOutput("EnPC",     32'(bus.EnPC),     32'(!st));
    checkOutput("EnIFID",   32'(bus.EnIFID),   32'(!st));
    checkOutput("FlushIF",  32'(bus.FlushIF),  32'(fl));
    checkOutput("FlushID",  32'(bus.FlushID),  32'(fl));
    checkOutput("State",    32'(bus.State),    (flushLeft > 0) ? 1 : 0);
    checkOutput("StallCnt", 32'(bus.StallCnt), 32'(stallCount));
    checkOutput("FlushCnt", 32'(bus.FlushCnt), 32'(flushCount));
  endtask

  task automatic advanceModel();
    bit st = modelStall();
    minstr_t n = noInstr();
    if (!(st || curBr || flushLeft > 0 || !curValid)) begin
      n.valid = 1;
      n.rd    = int'(curInstr[11:7]);
      n.rs1   = curRs1();
      n.rs2   = curRs2();
      n.regwr = curWr;
      n.memrd = curMr;
    end
    pipe.push_front(n);
    void'(pipe.pop_back());
    if (st && stallCount < MAX_CNT) stallCount++;
    if (curBr) begin
      if (flushCount < MAX_CNT) flushCount++;
      flushLeft = FLUSH_CYCLES;
    end else if (flushLeft > 0) begin
      flushLeft--;
    end
  endtask

  // Drives the ID side for one cycle and checks every output at the following falling edge.
  task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit wr, input bit mr, input bit br);
    curValid = v; curInstr = instr; curWr = wr; curMr = mr; curBr = br;
    bus.IdValid   = v;
    bus.IdInstr   = instr;
    bus.IdRegWR   = wr;
    bus.IdMemRead = mr;
    bus.BranchF   = br;
    @(negedge clk);
    checkAll();
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
    advanceModel();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 32'd0, 0, 0, 0);
    endCycle();
  endtask

  initial begin
    logic [31:0] rInstr;
    bit rValid, rWr, rMr, rBr, prevStall;

    rst_n = 1'b0;
    bus.IdValid = 0; bus.IdInstr = '0; bus.IdRegWR = 0; bus.IdMemRead = 0; bus.BranchF = 0;
    curValid = 0; curInstr = '0; curWr = 0; curMr = 0; curBr = 0;
    modelReset();
    #2;
    checkOutput("rstState",   32'(bus.State),   0);
    checkOutput("rstEnPC",    32'(bus.EnPC),    0);
    checkOutput("rstFlushIF", 32'(bus.FlushIF), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset in the middle of a flush clears everything asynchronously.
    applyStimulus(1, mkInstr(3, 0, 0), 1, 0, 0); endCycle();
    applyStimulus(1, mkInstr(4, 3, 0), 1, 0, 1); endCycle();
    checkOutput("preRstState", 32'(bus.State), 1);
    bus.BranchF = 0; bus.IdValid = 0;
    curBr = 0; curValid = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstState",    32'(bus.State),    0);
    checkOutput("midRstFlushIF",  32'(bus.FlushIF),  0);
    checkOutput("midRstFlushID",  32'(bus.FlushID),  0);
    checkOutput("midRstRegDEX",   32'(bus.RegDEX),   0);
    checkOutput("midRstRegDMEM",  32'(bus.RegDMEM),  0);
    checkOutput("midRstRegDWB",   32'(bus.RegDWB),   0);
    checkOutput("midRstStallCnt", 32'(bus.StallCnt), 0);
    checkOutput("midRstFlushCnt", 32'(bus.FlushCnt), 0);
    modelReset();
    #1 rst_n = 1'b1;

    // Load-use: lw x9 in EX with add x10,x9,x1 in ID.
    applyStimulus(1, mkInstr(9, 2, 0), 1, 1, 0); endCycle();
    applyStimulus(1, mkInstr(10, 9, 1), 1, 0, 0);
    checkOutput("luStall", 32'(bus.Stall), 1);
    checkOutput("luEnPC",  32'(bus.EnPC),  0);
    endCycle();
    applyStimulus(1, mkInstr(10, 9, 1), 1, 0, 0);
    checkOutput("luStallOnce", 32'(bus.Stall),  0);
    checkOutput("luBubbleEX",  32'(bus.RegDEX), 0);
    endCycle();
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("luFwA",      32'(bus.FwASel),   2);
    checkOutput("luStallCnt", 32'(bus.StallCnt), 1);
    checkOutput("luRegDEX",   32'(bus.RegDEX),   10);
    endCycle();

    // MEM forwarding: addi x5 then sub x6,x5,x7.
    applyStimulus(1, mkInstr(5, 0, 0), 1, 0, 0); endCycle();
    applyStimulus(1, mkInstr(6, 5, 7), 1, 0, 0); endCycle();
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("memFwA", 32'(bus.FwASel), 1);
    checkOutput("memFwB", 32'(bus.FwBSel), 0);
    endCycle();

    // Two writers of x5 in flight: the younger (MEM) wins for both operands.
    applyStimulus(1, mkInstr(5, 1, 0), 1, 0, 0); endCycle();
    applyStimulus(1, mkInstr(5, 2, 0), 1, 0, 0); endCycle();
    applyStimulus(1, mkInstr(8, 5, 5), 1, 0, 0); endCycle();
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("prioFwA", 32'(bus.FwASel), 1);
    checkOutput("prioFwB", 32'(bus.FwBSel), 1);
    endCycle();

    // Same pattern on x0: never forwarded.
    applyStimulus(1, mkInstr(0, 1, 0), 1, 0, 0); endCycle();
    applyStimulus(1, mkInstr(0, 2, 0), 1, 0, 0); endCycle();
    applyStimulus(1, mkInstr(8, 0, 0), 1, 0, 0); endCycle();
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("x0FwA", 32'(bus.FwASel), 0);
    checkOutput("x0FwB", 32'(bus.FwBSel), 0);
    endCycle();

    // Branch flush with valid instructions offered throughout.
    applyStimulus(1, mkInstr(12, 1, 2), 1, 0, 1);
    checkOutput("brT0FlushIF", 32'(bus.FlushIF), 1);
    checkOutput("brT0FlushID", 32'(bus.FlushID), 1);
    checkOutput("brT0State",   32'(bus.State),   0);
    endCycle();
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(1, mkInstr(13, 1, 2), 1, 0, 0);
      checkOutput("brFlushState", 32'(bus.State),   1);
      checkOutput("brFlushIF",    32'(bus.FlushIF), 1);
      checkOutput("brNoValidEX",  32'(bus.RegDEX),  0);
      endCycle();
    end
    applyStimulus(1, mkInstr(14, 1, 2), 1, 0, 0);
    checkOutput("brT3State",    32'(bus.State),    0);
    checkOutput("brT3FlushIF",  32'(bus.FlushIF),  0);
    checkOutput("brT3NoValid",  32'(bus.RegDEX),   0);
    checkOutput("brT3FlushCnt", 32'(bus.FlushCnt), 1);
    endCycle();
    idleCycle();
    idleCycle();

    // BranchF coincident with a load-use hit, then a second BranchF restarting the flush.
    applyStimulus(1, mkInstr(9, 2, 0), 1, 1, 0); endCycle();
    applyStimulus(1, mkInstr(10, 9, 1), 1, 0, 1);
    checkOutput("coStall",   32'(bus.Stall),   0);
    checkOutput("coEnPC",    32'(bus.EnPC),    1);
    checkOutput("coFlushIF", 32'(bus.FlushIF), 1);
    endCycle();
    applyStimulus(1, mkInstr(10, 9, 1), 1, 0, 1); endCycle();
    for (int k = 2; k <= 3; k++) begin
      applyStimulus(1, mkInstr(11, 1, 1), 1, 0, 0);
      checkOutput("coExtState",   32'(bus.State),   1);
      checkOutput("coExtFlushID", 32'(bus.FlushID), 1);
      endCycle();
    end
    applyStimulus(0, 32'd0, 0, 0, 0);
    checkOutput("coEndState",    32'(bus.State),    0);
    checkOutput("coEndFlushCnt", 32'(bus.FlushCnt), 3);
    checkOutput("coEndStallCnt", 32'(bus.StallCnt), 1);
    endCycle();

    // Random traffic on a small register set; a stalled ID instruction is re-offered.
    prevStall = 0;
    rInstr = '0; rValid = 0; rWr = 0; rMr = 0;
    for (int n = 0; n < 400; n++) begin
      if (!prevStall) begin
        rInstr = mkInstr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        rValid = ($urandom_range(0, 99) < 85);
        rWr    = ($urandom_range(0, 99) < 75);
        rMr    = rWr && ($urandom_range(0, 99) < 35);
      end
      rBr = ($urandom_range(0, 99) < 8);
      applyStimulus(rValid, rInstr, rWr, rMr, rBr);
      prevStall = modelStall();
      endCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
